sa_share_arbiter: RTL

- Round-robin scheduler that shares one SA_wrapper (16x16 systolic array) between N_REQ attention-head controllers.
- Each head raises a one-cycle start pulse. The arbiter queues it, grants the array, and issues the SA start. It then routes the SA completion back to the granted head.
- Matrix operand/result steering is done by an external mux driven by O_GRANT_IDX; this block only sequences control.
- Includes a watchdog that drops a job if the SA never completes.

---
 rtl/sa_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sa_share_arbiter.sv
// Round-robin sharing of one systolic-array wrapper between N_REQ head
// controllers: queues start pulses, grants the array, issues the SA start,
// routes completion back, and aborts a job whose completion never arrives.
module sa_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             I_CLK,
  input  logic             I_ASYN_RSTN,
  input  logic             I_SYNC_RSTN,
  input  logic [N_REQ-1:0] I_REQ_START,
  input  logic             I_SA_VLD,
  output logic             O_SA_START,
  output logic [IDX_W-1:0] O_GRANT_IDX,
  output logic [N_REQ-1:0] O_GRANT_OH,
  output logic [N_REQ-1:0] O_REQ_VLD,
  output logic [N_REQ-1:0] O_PENDING,
  output logic             O_BUSY,
  output logic [N_REQ-1:0] O_TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [TO_W-1:0]  watchdog;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_oh;
  int unsigned      cand;

  // Pick the first pending head after last_grant, wrapping modulo N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= unsigned'(N_REQ); i++) begin
      cand = (32'(last_grant) + i) % unsigned'(N_REQ);
      if (!sel_found && O_PENDING[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
    sel_oh = N_REQ'(1) << sel_idx;
  end

  // Control FSM with request queue, watchdog and all registered outputs.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state         <= S_IDLE;
      last_grant    <= IDX_W'(N_REQ - 1);
      watchdog      <= '0;
      O_SA_START    <= 1'b0;
      O_GRANT_IDX   <= '0;
      O_GRANT_OH    <= '0;
      O_REQ_VLD     <= '0;
      O_PENDING     <= '0;
      O_BUSY        <= 1'b0;
      O_TIMEOUT_ERR <= '0;
    end else if (!I_SYNC_RSTN) begin
      state         <= S_IDLE;
      last_grant    <= IDX_W'(N_REQ - 1);
      watchdog      <= '0;
      O_SA_START    <= 1'b0;
      O_GRANT_IDX   <= '0;
      O_GRANT_OH    <= '0;
      O_REQ_VLD     <= '0;
      O_PENDING     <= '0;
      O_BUSY        <= 1'b0;
      O_TIMEOUT_ERR <= '0;
    end else begin
      O_SA_START <= 1'b0;
      O_REQ_VLD  <= '0;
      O_PENDING  <= O_PENDING | I_REQ_START;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            O_GRANT_IDX <= sel_idx;
            O_GRANT_OH  <= sel_oh;
            last_grant  <= sel_idx;
            // Clear beats a coincident start only for the head being granted.
            O_PENDING   <= (O_PENDING | I_REQ_START) & ~sel_oh;
            O_BUSY      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          O_SA_START <= 1'b1;
          watchdog   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (I_SA_VLD) begin
            O_REQ_VLD <= O_GRANT_OH;
            O_BUSY    <= 1'b0;
            state     <= S_GAP;
          end else if (watchdog == TO_W'(TIMEOUT - 1)) begin
            O_TIMEOUT_ERR <= O_TIMEOUT_ERR | O_GRANT_OH;
            O_BUSY        <= 1'b0;
            state         <= S_GAP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        S_GAP: begin
          O_GRANT_OH <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
